// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order store write buffer draining one store per cycle to the pmem write port
// Optional same-word store merging into the newest entry: STORE_BUF_COALESCE_EN
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ADDR_W-1:0]          req_addr_i,
  input  logic [DATA_W/8-1:0]        req_strb_i,
  input  logic [DATA_W-1:0]          req_data_i,
  input  logic                       drain_stall_i,
  output logic                       pmem_en_o,
  output logic [ADDR_W-1:0]          pmem_addr_o,
  output logic [DATA_W/8-1:0]        pmem_strb_o,
  output logic [DATA_W-1:0]          pmem_data_o,
  input  logic [ADDR_W-1:0]          ld_addr_i,
  output logic                       ld_hit_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [STRB_W-1:0] ent_strb_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              out_en_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [STRB_W-1:0] out_strb_q;
  logic [DATA_W-1:0] out_data_q;

  logic              pop;
  logic              accept;
  logic              merge;
  logic              push_new;
  logic [PTR_W-1:0]  slot_off;
  logic              unused_ld_lsb;

  assign req_ready_o = (count_q != CNT_W'(DEPTH));
  assign pop         = (count_q != '0) && !drain_stall_i;
  // Zero-strobe stores are acknowledged but never occupy an entry.
  assign accept      = req_valid_i && req_ready_o && (req_strb_i != '0);

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] last_idx;
  assign last_idx = tail_q - PTR_W'(1);
  // A lone entry leaving this edge cannot absorb the request; it gets its own slot.
  assign merge = accept && (count_q != '0)
               && (ent_addr_q[last_idx][ADDR_W-1:2] == req_addr_i[ADDR_W-1:2])
               && !((count_q == CNT_W'(1)) && pop);
`else
  assign merge = 1'b0;
`endif

  assign push_new = accept && !merge;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push_new) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (push_new && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_new && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Entry storage needs no reset: validity is derived from head/count.
  always_ff @(posedge clock) begin
    if (push_new) begin
      ent_addr_q[tail_q] <= req_addr_i;
      ent_strb_q[tail_q] <= req_strb_i;
      ent_data_q[tail_q] <= req_data_i;
    end
`ifdef STORE_BUF_COALESCE_EN
    else if (merge) begin
      ent_strb_q[last_idx] <= ent_strb_q[last_idx] | req_strb_i;
      for (int b = 0; b < STRB_W; b++) begin
        if (req_strb_i[b]) begin
          ent_data_q[last_idx][8*b +: 8] <= req_data_i[8*b +: 8];
        end
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_en_q   <= 1'b0;
      out_addr_q <= '0;
      out_strb_q <= '0;
      out_data_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      out_en_q <= pop;
      if (pop) begin
        out_addr_q <= ent_addr_q[head_q];
        out_strb_q <= ent_strb_q[head_q];
        out_data_q <= ent_data_q[head_q];
      end
    end
  end

  always_comb begin
    slot_off = '0;
    ld_hit_o = out_en_q && (out_addr_q[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]);
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - head_q;
      if ((CNT_W'(slot_off) < count_q)
          && (ent_addr_q[i][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])) begin
        ld_hit_o = 1'b1;
      end
    end
  end

  assign unused_ld_lsb = ^ld_addr_i[1:0];

  assign pmem_en_o   = out_en_q;
  assign pmem_addr_o = out_addr_q;
  assign pmem_strb_o = out_strb_q;
  assign pmem_data_o = out_data_q;
  assign empty_o     = (count_q == '0) && !out_en_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - directed and random checks of store_write_buffer against a queue model
module tb_store_write_buffer;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [3:0]  req_strb_i;
  logic [31:0] req_data_i;
  logic        drain_stall_i;
  logic        pmem_en_o;
  logic [31:0] pmem_addr_o;
  logic [3:0]  pmem_strb_o;
  logic [31:0] pmem_data_o;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic        empty_o;
  logic [2:0]  count_o;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_strb_i(req_strb_i), .req_data_i(req_data_i),
    .drain_stall_i(drain_stall_i),
    .pmem_en_o(pmem_en_o), .pmem_addr_o(pmem_addr_o),
    .pmem_strb_o(pmem_strb_o), .pmem_data_o(pmem_data_o),
    .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o),
    .empty_o(empty_o), .count_o(count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_en;
  logic [31:0] m_addr;
  logic [3:0]  m_strb;
  logic [31:0] m_data;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hit(input logic [31:0] la);
    logic h;
    h = m_en && (m_addr[31:2] == la[31:2]);
    foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) h = 1'b1;
    return h;
  endfunction

  // Called at posedge+1: drive inputs, check combinational outputs, advance one edge, check state.
  task automatic step(input logic v, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic st, input logic [31:0] la);
    ent_t e;
    logic pop, push, merge, rdy;
    req_valid_i = v; req_addr_i = a; req_strb_i = s; req_data_i = d;
    drain_stall_i = st; ld_addr_i = la;
    #1;
    rdy = (q.size() < DEPTH);
    check("ready_pre", req_ready_o, rdy);
    check("ld_hit", ld_hit_o, model_hit(la));
    pop   = (q.size() != 0) && !st;
    push  = v && rdy && (s != 4'h0);
    merge = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    if (push && q.size() >= 1 && q[q.size()-1].addr[31:2] == a[31:2] && !(q.size() == 1 && pop))
      merge = 1'b1;
`endif
    if (pop) begin
      e = q.pop_front();
      m_en = 1'b1; m_addr = e.addr; m_strb = e.strb; m_data = e.data;
    end else begin
      m_en = 1'b0;
    end
    if (merge) begin
      e = q[q.size()-1];
      for (int b = 0; b < 4; b++) if (s[b]) e.data[8*b +: 8] = d[8*b +: 8];
      e.strb = e.strb | s;
      q[q.size()-1] = e;
    end else if (push) begin
      e.addr = a; e.strb = s; e.data = d;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    check("count", count_o, q.size());
    check("ready", req_ready_o, q.size() < DEPTH);
    check("empty", empty_o, (q.size() == 0) && !m_en);
    check("pmem_en", pmem_en_o, m_en);
    check("pmem_addr", pmem_addr_o, m_addr);
    check("pmem_strb", pmem_strb_o, m_strb);
    check("pmem_data", pmem_data_o, m_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    total = 0; bad = 0;
    m_en = 1'b0; m_addr = '0; m_strb = '0; m_data = '0;
    reset_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_strb_i = '0;
    req_data_i = '0; drain_stall_i = 1'b0; ld_addr_i = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", count_o, 0);
    check("rst_ready", req_ready_o, 1);
    check("rst_empty", empty_o, 1);
    check("rst_en", pmem_en_o, 0);
    check("rst_hit", ld_hit_o, 0);
    reset_n = 1'b1;

    // Single store: visible on pmem two edges after acceptance, for one cycle.
    step(1'b1, 32'h8000_0004, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
    check("single_cnt1", count_o, 1);
    check("single_en0", pmem_en_o, 0);
    idle(1);
    check("single_en1", pmem_en_o, 1);
    check("single_addr", pmem_addr_o, 32'h8000_0004);
    check("single_data", pmem_data_o, 32'hDEAD_BEEF);
    check("single_cnt0", count_o, 0);
    idle(1);
    check("single_en_off", pmem_en_o, 0);

    // Fill under stall, attempt overflow, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h2000 + 32'(i*4), 4'hF, 32'h1111_0000 + 32'(i), 1'b1, 32'h0);
    check("full_ready", req_ready_o, 0);
    check("full_count", count_o, DEPTH);
    step(1'b1, 32'h3000, 4'hF, 32'hBAD0_BAD0, 1'b1, 32'h3000);
    check("full_hold", count_o, DEPTH);
    idle(DEPTH + 1);
    check("drain_done", count_o, 0);

    // Steady push+pop with two entries resident.
    step(1'b1, 32'h4000, 4'hF, 32'hA000_0000, 1'b1, 32'h0);
    step(1'b1, 32'h4010, 4'hF, 32'hA000_0001, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h4020 + 32'(i*16), 4'hF, 32'hA000_0002 + 32'(i), 1'b0, 32'h0);
      check("simul_count", count_o, 2);
    end
    idle(3);

    // Load hazard is word granular.
    step(1'b1, 32'h8000_0010, 4'hF, 32'h5555_5555, 1'b1, 32'h0);
    ld_addr_i = 32'h8000_0013; #1;
    check("hazard_hit", ld_hit_o, 1);
    ld_addr_i = 32'h8000_0014; #1;
    check("hazard_miss", ld_hit_o, 0);
    idle(2);

    // Asynchronous reset with pending entries.
    step(1'b1, 32'h6000, 4'hF, 32'h6, 1'b1, 32'h0);
    step(1'b1, 32'h6010, 4'hF, 32'h7, 1'b0, 32'h0);
    step(1'b1, 32'h6020, 4'hF, 32'h8, 1'b1, 32'h0);
    step(1'b1, 32'h6030, 4'hF, 32'h9, 1'b1, 32'h0);
    req_valid_i = 1'b0; ld_addr_i = 32'h6010;
    reset_n = 1'b0; #1;
    check("mid_rst_en", pmem_en_o, 0);
    check("mid_rst_addr", pmem_addr_o, 0);
    check("mid_rst_data", pmem_data_o, 0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_ready", req_ready_o, 1);
    check("mid_rst_empty", empty_o, 1);
    check("mid_rst_hit", ld_hit_o, 0);
    q.delete();
    m_en = 1'b0; m_addr = '0; m_strb = '0; m_data = '0;
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    idle(4);

    // Two stores into the same word.
    step(1'b1, 32'h100, 4'h3, 32'h0000_1122, 1'b1, 32'h0);
    step(1'b1, 32'h102, 4'hC, 32'h3344_0000, 1'b1, 32'h0);
`ifdef STORE_BUF_COALESCE_EN
    check("coal_count", count_o, 1);
    idle(1);
    check("coal_strb", pmem_strb_o, 4'hF);
    check("coal_data", pmem_data_o, 32'h3344_1122);
`else
    check("nocoal_count", count_o, 2);
    idle(1);
    check("nocoal_strb", pmem_strb_o, 4'h3);
    check("nocoal_data", pmem_data_o, 32'h0000_1122);
`endif
    idle(3);

    // Random traffic on a small address pool so merges, hits and zero strobes occur.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 32'h1000 + $urandom_range(0, 15),
           4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 9) < 3,
           32'h1000 + $urandom_range(0, 19));
    end
    idle(DEPTH + 2);
    check("final_empty", empty_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Buffers store requests from the LSU and drains them, one per cycle, into the physical-memory write port that feeds the pmem write DPI model. It decouples store issue from memory-side stalls, holds up to DEPTH pending stores in order, and tells the load path when a load word-address collides with a pending store. It sits directly upstream of the pmem write DPI wrapper, whose inputs are driven by this block's pmem_* outputs.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- ADDR_W, 32: address width
- DATA_W, 32: data width; strobe width is DATA_W/8
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  store request valid
- req_ready_o  out  1  buffer can accept; equals !full
- req_addr_i  in  ADDR_W  store byte address
- req_strb_i  in  DATA_W/8  byte enables
- req_data_i  in  DATA_W  store data
- drain_stall_i  in  1  blocks pop this cycle
- pmem_en_o  out  1  write enable to pmem write port
- pmem_addr_o  out  ADDR_W  write address
- pmem_strb_o  out  DATA_W/8  write strobe
- pmem_data_o  out  DATA_W  write data
- ld_addr_i  in  ADDR_W  load address for hazard check
- ld_hit_o  out  1  pending store to same word
- empty_o  out  1  FIFO empty and pmem_en_o low
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH) bits that wrap naturally; separate count register, 0..DEPTH.
- Push: req_valid_i && req_ready_o at posedge writes {addr, strb, data} at tail. A push with req_strb_i == 0 is accepted and dropped (no entry, no count change).
- Pop: at posedge, if count != 0 and !drain_stall_i, head entry loads the output registers and pmem_en_o is 1 next cycle; otherwise pmem_en_o is 0 next cycle, and pmem_addr_o/strb_o/data_o hold their previous values.
- Simultaneous push and pop: both happen; count unchanged. With count == DEPTH, ready is 0, so no push; pop proceeds.
- req_ready_o depends only on count. There is no combinational path from req_valid_i or drain_stall_i.
- ld_hit_o: combinational OR over valid FIFO entries plus the output register (when pmem_en_o = 1) of (entry.addr[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]).
- Reset (any time, including mid-drain): all entries discarded; count, head and tail are 0; pmem_en_o, pmem_addr_o, pmem_strb_o and pmem_data_o are 0; req_ready_o = 1; ld_hit_o = 0; empty_o = 1. In-flight stores are lost by design.

## Timing
- Store accepted at edge N with an empty buffer and no stall: popped at edge N+1; pmem_en_o is high for cycle N+1..N+2, so the DPI wrapper samples it at edge N+2.
- Sustained throughput is one store per cycle; order is strictly FIFO.
- drain_stall_i asserted in cycle k suppresses the pop at the edge ending cycle k only.
- req_ready_o, count_o and empty_o are registered-state outputs and are valid right after each edge.

## Configuration
- STORE_BUF_COALESCE_EN defined:
  - An accepted request whose word address equals the tail entry's (newest entry, count ≥ 1) merges into that entry: strb |= req_strb; data bytes with req_strb set are overwritten.
  - Count is unchanged.
  - Merging is forbidden when count == 1 and that entry is popped at the same edge; the request is then pushed normally.
  - req_ready_o remains !full, so there is no merge into a full buffer.
- Undefined: every accepted request occupies its own entry; no merge logic is present.

## Test plan
- Single store: push addr 0x8000_0004, strb 0xF, data 0xDEADBEEF, no stall -> pmem_en_o = 1 exactly one cycle, two edges later, with identical addr/strb/data; count_o returns to 0.
- Fill: drain_stall_i = 1, push DEPTH stores -> req_ready_o = 0 and count_o = DEPTH; a further valid request is not accepted. Release stall -> DEPTH consecutive pmem_en_o cycles in push order.
- Simultaneous: with count = 2 and no stall, push every cycle for 10 cycles -> count_o stays at 2; outputs match input order; pointer wrap is exercised.
- Hazard: stall, push 0x8000_0010 -> ld_addr_i = 0x8000_0013 gives ld_hit_o = 1; ld_addr_i = 0x8000_0014 gives ld_hit_o = 0.
- Reset mid-operation: 3 entries pending, drop reset_n between edges -> all outputs 0 immediately, no pmem_en_o after release.
- Coalesce (macro on): stall, push 0x100/strb 0x3/data 0x0000_1122, then 0x102/strb 0xC/data 0x3344_0000 -> count_o = 1; drain emits strb 0xF, data 0x3344_1122. Macro off -> two writes.
